// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared types and constants for the staged peripheral reset
//                sequencer (state encoding, CSR bit positions, defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // CSR bit positions
    localparam int CTRL_RESTART = 7;   // write 1 here to (re)start the sequence
    localparam int STAT_DONE    = 7;   // read-back of the done flag

    // Bus and counter widths
    localparam int c_csr_aw     = 5;
    localparam int c_csr_dw     = 8;
    localparam int c_cnt_w      = 8;
    localparam int c_idx_w      = 3;   // enough for up to 7 stages
    localparam int c_max_stages = 7;

    // Defaults
    localparam logic [c_cnt_w-1:0]  DEFAULT_STAGE_DELAY = 8'd33;  // ~1 ms at 32 kHz
    localparam logic [c_csr_aw-1:0] DEFAULT_BASE_ADDR   = 5'h1d;

    // A programmed delay of zero behaves as one tick
    function automatic logic [c_cnt_w-1:0] eff_delay(input logic [c_cnt_w-1:0] d);
        return (d == '0) ? c_cnt_w'(1) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reset_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_if
//  Description : CSR bus bundle for the reset sequencer status/control
//                register (address, write data, write strobe, read data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface reset_seq_if;
    import reset_seq_pkg::*;

    logic [c_csr_aw-1:0] csr_a;
    logic [c_csr_dw-1:0] csr_di;
    logic                csr_we;
    logic [c_csr_dw-1:0] csr_do;

    // Bus master drives address/data/strobe and samples read data
    modport master (
        output csr_a,
        output csr_di,
        output csr_we,
        input  csr_do
    );

    // The sequencer decodes the bus and returns read data
    modport slave (
        input  csr_a,
        input  csr_di,
        input  csr_we,
        output csr_do
    );

endinterface
`default_nettype wire

// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq
//  Description : Staged peripheral reset sequencer. After a restart (start
//                pulse or CSR write with bit 7 set) it releases the reset
//                lines one by one, STAGE_DELAY ce ticks apart. Released
//                stages follow their hold input live; unreleased stages stay
//                asserted. Status is readable at BASE_ADDR.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter logic [c_csr_aw-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int                  NUM_STAGES  = 4,
    parameter logic [c_cnt_w-1:0]  STAGE_DELAY = DEFAULT_STAGE_DELAY
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  ce,
    input  wire logic                  start,
    input  wire logic [NUM_STAGES-1:0] hold,
    reset_seq_if.slave                 csr,
    output logic      [NUM_STAGES-1:0] rst_out,
    output logic                       done
);

    // Terminal count of the inter-stage delay and index of the last stage
    localparam logic [c_cnt_w-1:0] c_last_cnt = eff_delay(STAGE_DELAY) - c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_STAGES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_idx_w-1:0]      r_idx;
    logic [c_idx_w-1:0]      w_idx_nxt;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_cnt_w-1:0]      w_cnt_nxt;
    logic [NUM_STAGES-1:0]   r_rel;       // stages whose slot has passed
    logic [NUM_STAGES-1:0]   w_rel_nxt;
    logic [NUM_STAGES-1:0]   r_rst_out;
    logic [NUM_STAGES-1:0]   w_rst_nxt;
    logic                    r_done;
    logic                    w_done_nxt;
    logic                    w_addr_hit;
    logic                    w_restart;
    logic [c_csr_dw-1:0]     w_csr_do;
    logic                    w_unused_di;

    // Only the restart bit of the write data carries meaning
    assign w_unused_di = ^csr.csr_di[c_csr_dw-2:0];

    // Address decode and the merged restart request (start and CSR collapse to one)
    assign w_addr_hit = (csr.csr_a == BASE_ADDR);
    assign w_restart  = start | (csr.csr_we & w_addr_hit & csr.csr_di[CTRL_RESTART]);

    // Next-state logic: restart wins over any release due in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_rel_nxt   = r_rel;
        if (w_restart) begin
            w_state_nxt = ST_COUNT;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
            w_rel_nxt   = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_rel_nxt = '0;
                end
                ST_COUNT: begin
                    if (ce) begin
                        if (r_cnt == c_last_cnt) begin
                            w_cnt_nxt = '0;
                            for (int i = 0; i < NUM_STAGES; i++) begin
                                if (r_idx == c_idx_w'(i)) begin
                                    w_rel_nxt[i] = 1'b1;
                                end
                            end
                            if (r_idx == c_last_idx) begin
                                w_state_nxt = ST_DONE;
                            end else begin
                                w_idx_nxt = r_idx + c_idx_w'(1);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                ST_DONE: begin
                    w_rel_nxt = r_rel;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rel_nxt   = '0;
                end
            endcase
        end
    end

    // Released stages mirror hold; the rest stay in reset
    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
            assign w_rst_nxt[g] = w_rel_nxt[g] ? hold[g] : 1'b1;
        end
    endgenerate

    assign w_done_nxt = (w_state_nxt == ST_DONE);

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rel     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rel     <= w_rel_nxt;
            r_rst_out <= w_rst_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Combinational status read: {done, zero pad, rst_out}
    always_comb begin
        w_csr_do = '0;
        if (w_addr_hit) begin
            w_csr_do[STAT_DONE]         = r_done;
            w_csr_do[NUM_STAGES-1:0]    = r_rst_out;
        end
    end

    assign csr.csr_do = w_csr_do;
    assign rst_out    = r_rst_out;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_seq
//  Description : Self-checking bench for reset_seq. Three instances with
//                STAGE_DELAY 3, 2 and 0; expected release timelines are
//                pushed to a scoreboard queue and popped after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq;

    localparam logic [4:0] BASE = 5'h1d;

    typedef struct {
        int         dut;
        logic [3:0] rst;
        logic       done;
        int         e;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] hold;
    logic       ce3, ce2, ce0;
    logic       start3, start2, start0;
    logic [3:0] rst3, rst2, rst0;
    logic       done3, done2, done0;

    int   total;
    int   bad;
    exp_t sb[$];

    reset_seq_if if3 ();
    reset_seq_if if2 ();
    reset_seq_if if0 ();

    reset_seq #(.BASE_ADDR(BASE), .NUM_STAGES(4), .STAGE_DELAY(8'd3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .ce(ce3), .start(start3), .hold(hold),
        .csr(if3), .rst_out(rst3), .done(done3)
    );

    reset_seq #(.BASE_ADDR(BASE), .NUM_STAGES(4), .STAGE_DELAY(8'd2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .ce(ce2), .start(start2), .hold(hold),
        .csr(if2), .rst_out(rst2), .done(done2)
    );

    reset_seq #(.BASE_ADDR(BASE), .NUM_STAGES(4), .STAGE_DELAY(8'd0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .ce(ce0), .start(start0), .hold(hold),
        .csr(if0), .rst_out(rst0), .done(done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int dut, input logic v);
        case (dut)
            0:       start3 = v;
            1:       start2 = v;
            default: start0 = v;
        endcase
    endtask

    task automatic set_ce(input int dut, input logic v);
        case (dut)
            0:       ce3 = v;
            1:       ce2 = v;
            default: ce0 = v;
        endcase
    endtask

    task automatic set_wr(input int dut, input logic we, input logic [4:0] a, input logic [7:0] di);
        case (dut)
            0:       begin if3.csr_we = we; if3.csr_a = a; if3.csr_di = di; end
            1:       begin if2.csr_we = we; if2.csr_a = a; if2.csr_di = di; end
            default: begin if0.csr_we = we; if0.csr_a = a; if0.csr_di = di; end
        endcase
    endtask

    function automatic logic [3:0] obs_rst(input int dut);
        case (dut)
            0:       return rst3;
            1:       return rst2;
            default: return rst0;
        endcase
    endfunction

    function automatic logic obs_done(input int dut);
        case (dut)
            0:       return done3;
            1:       return done2;
            default: return done0;
        endcase
    endfunction

    // Restart one instance at edge E0 and check every edge up to E0+nedges.
    // ce is high on edges where (e % period) == phase; releases happen every d counted ce.
    task automatic run_seq(input int dut, input int d, input int period, input int phase,
                           input int nedges, input bit use_csr, input string tag);
        int         nce;
        int         nrel;
        logic [3:0] rel;
        logic       ce_now;
        exp_t       item;
        nce = 0;
        if (use_csr) set_wr(dut, 1'b1, BASE, 8'h80);
        else         set_start(dut, 1'b1);
        for (int e = 0; e <= nedges; e++) begin
            ce_now = ((e % period) == phase);
            set_ce(dut, ce_now);
            if (ce_now && (e > 0)) nce++;
            nrel = nce / d;
            if (nrel > 4) nrel = 4;
            rel       = 4'((1 << nrel) - 1);
            item.dut  = dut;
            item.rst  = ~rel | (hold & rel);
            item.done = (nrel == 4);
            item.e    = e;
            sb.push_back(item);
            tick();
            if (e == 0) begin
                set_start(dut, 1'b0);
                set_wr(dut, 1'b0, BASE, 8'h00);
            end
            item = sb.pop_front();
            chk($sformatf("%s_rst_e%0d", tag, item.e), {4'h0, obs_rst(item.dut)}, {4'h0, item.rst});
            chk($sformatf("%s_done_e%0d", tag, item.e), {7'h0, obs_done(item.dut)}, {7'h0, item.done});
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        hold   = 4'h0;
        ce3    = 1'b0; ce2    = 1'b0; ce0    = 1'b0;
        start3 = 1'b0; start2 = 1'b0; start0 = 1'b0;
        set_wr(0, 1'b0, 5'h00, 8'h00);
        set_wr(1, 1'b0, 5'h00, 8'h00);
        set_wr(2, 1'b0, 5'h00, 8'h00);
        tick();
        tick();

        // Reset state
        chk("reset_rst3", {4'h0, rst3}, 8'h0f);
        chk("reset_rst2", {4'h0, rst2}, 8'h0f);
        chk("reset_rst0", {4'h0, rst0}, 8'h0f);
        chk("reset_done3", {7'h0, done3}, 8'h00);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_rst3", {4'h0, rst3}, 8'h0f);
        if3.csr_a = BASE;
        #1;
        chk("idle_csr_do", if3.csr_do, 8'h0f);
        if3.csr_a = 5'h00;
        #1;
        chk("idle_csr_other", if3.csr_do, 8'h00);

        // Plain release sequence, D=3, ce every cycle
        run_seq(0, 3, 1, 0, 14, 1'b0, "seq");
        if3.csr_a = BASE;
        #1;
        chk("done_csr_do", if3.csr_do, 8'h80);
        if3.csr_a = 5'h00;

        // Restart from DONE with hold on stage 2
        hold = 4'b0100;
        run_seq(0, 3, 1, 0, 13, 1'b0, "hold");
        hold = 4'b0000;
        tick();
        chk("hold_drop_rst", {4'h0, rst3}, 8'h00);
        chk("hold_drop_done", {7'h0, done3}, 8'h01);

        // Restart in COUNT via CSR write, after stage 0 has been released
        run_seq(0, 3, 1, 0, 4, 1'b0, "pre_csr");
        run_seq(0, 3, 1, 0, 13, 1'b1, "csr_restart");

        // Async reset mid-sequence
        run_seq(0, 3, 1, 0, 7, 1'b0, "pre_arst");
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_rst_now", {4'h0, rst3}, 8'h0f);
        chk("arst_done_now", {7'h0, done3}, 8'h00);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("arst_hold_rst_%0d", i), {4'h0, rst3}, 8'h0f);
            chk($sformatf("arst_hold_done_%0d", i), {7'h0, done3}, 8'h00);
        end

        // Sparse ce on the D=2 instance: ce every 4th edge
        run_seq(1, 2, 4, 2, 32, 1'b0, "sparse");

        // STAGE_DELAY=0 behaves as 1
        run_seq(2, 1, 1, 0, 5, 1'b0, "d0");

        // CSR decode on the D=0 instance
        if0.csr_a = BASE + 5'd1;
        #1;
        chk("rd_base_plus1", if0.csr_do, 8'h00);
        if0.csr_a = BASE;
        #1;
        chk("rd_base_done", if0.csr_do, 8'h80);
        set_wr(2, 1'b1, BASE, 8'h7f);
        tick();
        set_wr(2, 1'b0, BASE, 8'h00);
        tick();
        chk("wr7f_rst", {4'h0, rst0}, 8'h00);
        chk("wr7f_done", {7'h0, done0}, 8'h01);
        chk("wr7f_csr_do", if0.csr_do, 8'h80);

        chk("sb_empty", 8'(sb.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
